// File: rtl/wb_mem_responder_pkg.sv
// Shared types and constants for the Wishbone memory responder.
// Defines the FSM states, the legal byte-lane strobe patterns and the lane-mask helper.
package wb_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_RELEASE
  } wb_state_t;

  localparam logic [3:0] WB_SEL_B0 = 4'b0001;
  localparam logic [3:0] WB_SEL_B1 = 4'b0010;
  localparam logic [3:0] WB_SEL_B2 = 4'b0100;
  localparam logic [3:0] WB_SEL_B3 = 4'b1000;
  localparam logic [3:0] WB_SEL_H0 = 4'b0011;
  localparam logic [3:0] WB_SEL_H1 = 4'b1100;
  localparam logic [3:0] WB_SEL_W  = 4'b1111;

  localparam int unsigned WAIT_CNT_W = 4;

  // Only naturally aligned byte, halfword and word accesses are accepted.
  function automatic logic sel_legal(input logic [3:0] sel);
    case (sel)
      WB_SEL_B0, WB_SEL_B1, WB_SEL_B2, WB_SEL_B3,
      WB_SEL_H0, WB_SEL_H1, WB_SEL_W: sel_legal = 1'b1;
      default:                        sel_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    lane_mask = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      lane_mask[8*i +: 8] = {8{sel[i]}};
    end
  endfunction

endpackage

// File: rtl/wb_mem_array.sv
// Single-port 32-bit word RAM with per-byte write enables and combinational read.
// Contents are never reset.
module wb_mem_array #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic [3:0]            i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdat,
  output logic [31:0]           o_rdat
);

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge i_clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (i_we[i]) begin
        mem[i_addr][8*i +: 8] <= i_wdat[8*i +: 8];
      end
    end
  end

  assign o_rdat = mem[i_addr];

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone slave fronting wb_mem_array: window decode, wait-state insertion,
// and exactly one ack/err pulse per request.
module wb_mem_responder
  import wb_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_wb_cyc,
  input  logic [3:0]  i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic        o_wb_err
);

  localparam logic [WAIT_CNT_W-1:0] CNT_INIT =
    (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

  wb_state_t             state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  logic [31:2] addr_q;
  logic        we_q;
  logic [31:0] dat_q;
  logic [3:0]  stb_q;

  logic        req;
  logic        enter_resp;
  logic        req_ok;
  logic [31:2] cur_addr;
  logic        cur_we;
  logic [31:0] cur_dat;
  logic [3:0]  cur_stb;

  logic [3:0]  mem_we;
  logic [31:0] mem_rdat;
  logic        ack_d, err_d;
  logic [31:0] rdat_d;

  logic        addr_lsb_unused;

  assign addr_lsb_unused = ^i_wb_addr[1:0];
  assign req = i_wb_cyc && (i_wb_stb != '0);

  // With zero wait states the response is decided on the accept edge itself,
  // so the live bus drives decode and RAM access while idle.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_addr = i_wb_addr[31:2];
      cur_we   = i_wb_we;
      cur_dat  = i_wb_dat;
      cur_stb  = i_wb_stb;
    end else begin
      cur_addr = addr_q;
      cur_we   = we_q;
      cur_dat  = dat_q;
      cur_stb  = stb_q;
    end
  end

  assign req_ok = (cur_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2])
               && sel_legal(cur_stb);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (!i_wb_cyc) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      ST_RESP:    state_d = ST_RELEASE;
      ST_RELEASE: begin
        if (!i_wb_cyc || (i_wb_stb == '0)) begin
          state_d = ST_IDLE;
        end
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);

  always_comb begin
    mem_we = '0;
    ack_d  = 1'b0;
    err_d  = 1'b0;
    rdat_d = o_wb_dat;
    if (enter_resp) begin
      ack_d  = req_ok;
      err_d  = !req_ok;
      rdat_d = '0;
      if (req_ok && cur_we) begin
        mem_we = cur_stb;
      end else if (req_ok) begin
        rdat_d = mem_rdat & lane_mask(cur_stb);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      addr_q <= '0;
      we_q   <= 1'b0;
      dat_q  <= '0;
      stb_q  <= '0;
    end else if ((state_q == ST_IDLE) && req) begin
      addr_q <= i_wb_addr[31:2];
      we_q   <= i_wb_we;
      dat_q  <= i_wb_dat;
      stb_q  <= i_wb_stb;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_wb_ack <= 1'b0;
      o_wb_err <= 1'b0;
      o_wb_dat <= '0;
    end else begin
      o_wb_ack <= ack_d;
      o_wb_err <= err_d;
      o_wb_dat <= rdat_d;
    end
  end

  wb_mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .i_clk  (i_clk),
    .i_we   (mem_we),
    .i_addr (cur_addr[ADDR_WIDTH+1:2]),
    .i_wdat (cur_dat),
    .o_rdat (mem_rdat)
  );

endmodule

// File: tb/tb_wb_mem_responder.sv
// Bench for wb_mem_responder: three instances (1, 3 and 0 wait states) sharing one
// bus driver, checked against a word-array reference model.
module tb_wb_mem_responder;

  localparam int NDUT = 3;

  logic        i_clk;
  logic        i_reset_n;
  logic        cyc;
  logic [3:0]  stb;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdat;
  int          sel;

  logic        cyc_v [NDUT];
  logic        ack_v [NDUT];
  logic        err_v [NDUT];
  logic [31:0] dat_v [NDUT];

  logic [31:0] mdl [NDUT][1024];
  int          checks;
  int          errors;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned WS = (g == 0) ? 1 : (g == 1) ? 3 : 0;
    assign cyc_v[g] = cyc && (sel == g);
    wb_mem_responder #(
      .ADDR_WIDTH  (10),
      .BASE_ADDR   (32'h0000_0000),
      .WAIT_STATES (WS)
    ) u_dut (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_wb_cyc  (cyc_v[g]),
      .i_wb_stb  (stb),
      .i_wb_we   (we),
      .i_wb_addr (addr),
      .i_wb_dat  (wdat),
      .o_wb_dat  (dat_v[g]),
      .o_wb_ack  (ack_v[g]),
      .o_wb_err  (err_v[g])
    );
  end

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 0;
  endfunction

  function automatic bit legal(input logic [3:0] s);
    return s inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
  endfunction

  function automatic logic [31:0] mask_of(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) if (s[i]) m = m | (32'hFF << (8 * i));
    return m;
  endfunction

  // Reference: 4 KiB window at address 0, byte-lane merge into a word array.
  task automatic model_access(input logic w, input logic [31:0] a, input logic [3:0] s,
                              input logic [31:0] d, output logic e_err, output logic [31:0] e_dat);
    int idx;
    logic [31:0] m;
    e_err = !(a < 32'h0000_1000) || !legal(s);
    e_dat = '0;
    if (!e_err) begin
      idx = int'(a / 4) % 1024;
      m   = mask_of(s);
      if (w) mdl[sel][idx] = (mdl[sel][idx] & ~m) | (d & m);
      else   e_dat = mdl[sel][idx] & m;
    end
  endtask

  task automatic wait_resp(output int lat, output logic ga, output logic ge, output logic [31:0] gd);
    lat = 0; ga = 1'b0; ge = 1'b0; gd = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      if (ack_v[sel] || err_v[sel]) begin
        lat = n; ga = ack_v[sel]; ge = err_v[sel]; gd = dat_v[sel];
        return;
      end
    end
  endtask

  task automatic bus_xfer(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                          output int lat, output logic ga, output logic ge,
                          output logic [31:0] gd, output logic ext);
    @(negedge i_clk);
    cyc = 1'b1; stb = s; we = w; addr = a; wdat = d;
    wait_resp(lat, ga, ge, gd);
    cyc = 1'b0; stb = '0;
    @(negedge i_clk);
    ext = ack_v[sel] | err_v[sel];
  endtask

  task automatic test_reset();
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if ({ack_v[d], err_v[d], dat_v[d]} !== 34'd0) begin
        errors++;
        $display("FAIL reset_state dut%0d: ack=%b err=%b dat=%h, want 0 0 00000000", d, ack_v[d], err_v[d], dat_v[d]);
      end
    end
  endtask

  task automatic test_basic();
    int lat; logic ga, ge, ext, e_err; logic [31:0] gd, e_dat;
    sel = 0;
    model_access(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, e_err, e_dat);
    bus_xfer(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, lat, ga, ge, gd, ext);
    checks++;
    if ({ga, ge, ext} !== 3'b100) begin
      errors++; $display("FAIL basic_write_resp: ack=%b err=%b tail=%b, want 1 0 0", ga, ge, ext);
    end
    checks++;
    if (lat != ws_of(sel) + 1) begin
      errors++; $display("FAIL basic_write_latency: got %0d, want %0d", lat, ws_of(sel) + 1);
    end
    model_access(1'b0, 32'h10, 4'hF, 32'h0, e_err, e_dat);
    bus_xfer(1'b0, 32'h10, 4'hF, 32'h0, lat, ga, ge, gd, ext);
    checks++;
    if (!(ga === 1'b1 && ge === 1'b0 && gd === 32'hDEAD_BEEF && gd === e_dat && lat == ws_of(sel) + 1)) begin
      errors++; $display("FAIL basic_read: ack=%b err=%b dat=%h lat=%0d, want 1 0 deadbeef %0d", ga, ge, gd, lat, ws_of(sel) + 1);
    end
  endtask

  task automatic test_byte_lanes();
    int lat; logic ga, ge, ext, e_err; logic [31:0] gd, e_dat;
    sel = 0;
    model_access(1'b1, 32'h10, 4'b0100, 32'h0000_00AA, e_err, e_dat);
    bus_xfer(1'b1, 32'h10, 4'b0100, 32'h0000_00AA, lat, ga, ge, gd, ext);
    model_access(1'b1, 32'h10, 4'b0100, 32'h00AA_0000, e_err, e_dat);
    bus_xfer(1'b1, 32'h10, 4'b0100, 32'h00AA_0000, lat, ga, ge, gd, ext);
    checks++;
    if ({ga, ge} !== 2'b10) begin
      errors++; $display("FAIL byte_write_resp: ack=%b err=%b, want 1 0", ga, ge);
    end
    model_access(1'b0, 32'h10, 4'hF, 32'h0, e_err, e_dat);
    bus_xfer(1'b0, 32'h10, 4'hF, 32'h0, lat, ga, ge, gd, ext);
    checks++;
    if (gd !== 32'hDEAA_BEEF || gd !== e_dat || ga !== 1'b1) begin
      errors++; $display("FAIL byte_read_word: dat=%h ack=%b, want deaabeef 1", gd, ga);
    end
    model_access(1'b0, 32'h12, 4'b1100, 32'h0, e_err, e_dat);
    bus_xfer(1'b0, 32'h12, 4'b1100, 32'h0, lat, ga, ge, gd, ext);
    checks++;
    if (gd !== 32'hDEAA_0000 || gd !== e_dat || ga !== 1'b1) begin
      errors++; $display("FAIL byte_read_half: dat=%h ack=%b, want deaa0000 1", gd, ga);
    end
  endtask

  task automatic test_errors();
    int lat; logic ga, ge, ext, e_err; logic [31:0] gd, e_dat;
    sel = 0;
    bus_xfer(1'b1, 32'h0000_1000, 4'hF, 32'hFFFF_FFFF, lat, ga, ge, gd, ext);
    checks++;
    if ({ga, ge, ext} !== 3'b010 || gd !== 32'h0 || lat != ws_of(sel) + 1) begin
      errors++; $display("FAIL err_out_of_window: ack=%b err=%b tail=%b dat=%h lat=%0d, want 0 1 0 0 %0d", ga, ge, ext, gd, lat, ws_of(sel) + 1);
    end
    bus_xfer(1'b1, 32'h10, 4'b0101, 32'h1234_5678, lat, ga, ge, gd, ext);
    checks++;
    if ({ga, ge, ext} !== 3'b010) begin
      errors++; $display("FAIL err_bad_strobe: ack=%b err=%b tail=%b, want 0 1 0", ga, ge, ext);
    end
    bus_xfer(1'b0, 32'h10, 4'hF, 32'h0, lat, ga, ge, gd, ext);
    bus_xfer(1'b0, 32'h10, 4'b0110, 32'h0, lat, ga, ge, gd, ext);
    checks++;
    if ({ga, ge} !== 2'b01 || gd !== 32'h0) begin
      errors++; $display("FAIL err_read_dat: ack=%b err=%b dat=%h, want 0 1 00000000", ga, ge, gd);
    end
    model_access(1'b0, 32'h10, 4'hF, 32'h0, e_err, e_dat);
    bus_xfer(1'b0, 32'h10, 4'hF, 32'h0, lat, ga, ge, gd, ext);
    checks++;
    if (gd !== e_dat || ga !== 1'b1) begin
      errors++; $display("FAIL err_mem_unchanged: dat=%h, want %h", gd, e_dat);
    end
    model_access(1'b1, 32'hFFC, 4'hF, 32'hA5A5_0FF0, e_err, e_dat);
    bus_xfer(1'b1, 32'hFFC, 4'hF, 32'hA5A5_0FF0, lat, ga, ge, gd, ext);
    model_access(1'b0, 32'hFFC, 4'hF, 32'h0, e_err, e_dat);
    bus_xfer(1'b0, 32'hFFC, 4'hF, 32'h0, lat, ga, ge, gd, ext);
    checks++;
    if (ga !== 1'b1 || gd !== e_dat) begin
      errors++; $display("FAIL top_word_of_window: ack=%b dat=%h, want 1 %h", ga, gd, e_dat);
    end
  endtask

  task automatic test_abort();
    int lat, seen; logic ga, ge, ext, e_err; logic [31:0] gd, e_dat;
    sel = 1;
    model_access(1'b1, 32'h20, 4'hF, 32'h1122_3344, e_err, e_dat);
    bus_xfer(1'b1, 32'h20, 4'hF, 32'h1122_3344, lat, ga, ge, gd, ext);
    checks++;
    if (ga !== 1'b1 || lat != ws_of(sel) + 1) begin
      errors++; $display("FAIL abort_setup_write: ack=%b lat=%0d, want 1 %0d", ga, lat, ws_of(sel) + 1);
    end
    seen = 0;
    @(negedge i_clk);
    cyc = 1'b1; stb = 4'hF; we = 1'b1; addr = 32'h20; wdat = 32'hCAFE_F00D;
    @(posedge i_clk);
    @(negedge i_clk); if (ack_v[sel] || err_v[sel]) seen++;
    @(posedge i_clk);
    @(negedge i_clk); if (ack_v[sel] || err_v[sel]) seen++;
    cyc = 1'b0;
    repeat (8) begin
      @(negedge i_clk); if (ack_v[sel] || err_v[sel]) seen++;
    end
    stb = '0;
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL abort_no_response: saw %0d response cycles, want 0", seen);
    end
    model_access(1'b0, 32'h20, 4'hF, 32'h0, e_err, e_dat);
    bus_xfer(1'b0, 32'h20, 4'hF, 32'h0, lat, ga, ge, gd, ext);
    checks++;
    if (ga !== 1'b1 || gd !== e_dat || lat != ws_of(sel) + 1) begin
      errors++; $display("FAIL abort_word_unchanged: ack=%b dat=%h lat=%0d, want 1 %h %0d", ga, gd, lat, e_dat, ws_of(sel) + 1);
    end
  endtask

  task automatic test_hold();
    int lat, extra; logic ga, ge, e_err; logic [31:0] gd, e_dat;
    sel = 0;
    model_access(1'b0, 32'h10, 4'hF, 32'h0, e_err, e_dat);
    @(negedge i_clk);
    cyc = 1'b1; stb = 4'hF; we = 1'b0; addr = 32'h10;
    wait_resp(lat, ga, ge, gd);
    extra = 0;
    repeat (5) begin
      @(negedge i_clk); if (ack_v[sel] || err_v[sel]) extra++;
    end
    checks++;
    if (ga !== 1'b1 || extra != 0) begin
      errors++; $display("FAIL hold_single_ack: first ack=%b extra responses=%0d, want 1 0", ga, extra);
    end
    cyc = 1'b0; stb = '0;
    @(negedge i_clk);
    cyc = 1'b1; stb = 4'hF;
    wait_resp(lat, ga, ge, gd);
    cyc = 1'b0; stb = '0;
    @(negedge i_clk);
    checks++;
    if (ga !== 1'b1 || lat != ws_of(sel) + 1 || gd !== e_dat) begin
      errors++; $display("FAIL hold_second_ack: ack=%b lat=%0d dat=%h, want 1 %0d %h", ga, lat, gd, ws_of(sel) + 1, e_dat);
    end
  endtask

  task automatic test_async_reset();
    int lat; logic ga, ge, ext, e_err; logic [31:0] gd, e_dat;
    sel = 1;
    model_access(1'b1, 32'h30, 4'hF, 32'h0BAD_F00D, e_err, e_dat);
    bus_xfer(1'b1, 32'h30, 4'hF, 32'h0BAD_F00D, lat, ga, ge, gd, ext);
    bus_xfer(1'b0, 32'h20, 4'hF, 32'h0, lat, ga, ge, gd, ext);
    @(negedge i_clk);
    cyc = 1'b1; stb = 4'hF; we = 1'b1; addr = 32'h30; wdat = 32'h55AA_55AA;
    @(posedge i_clk);
    @(posedge i_clk);
    #2 i_reset_n = 1'b0;
    #1;
    checks++;
    if ({ack_v[sel], err_v[sel], dat_v[sel]} !== 34'd0) begin
      errors++; $display("FAIL async_reset_outputs: ack=%b err=%b dat=%h, want 0 0 00000000", ack_v[sel], err_v[sel], dat_v[sel]);
    end
    cyc = 1'b0; stb = '0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    model_access(1'b0, 32'h30, 4'hF, 32'h0, e_err, e_dat);
    bus_xfer(1'b0, 32'h30, 4'hF, 32'h0, lat, ga, ge, gd, ext);
    checks++;
    if (ga !== 1'b1 || gd !== e_dat) begin
      errors++; $display("FAIL reset_ram_kept_0x30: ack=%b dat=%h, want 1 %h", ga, gd, e_dat);
    end
    model_access(1'b0, 32'h20, 4'hF, 32'h0, e_err, e_dat);
    bus_xfer(1'b0, 32'h20, 4'hF, 32'h0, lat, ga, ge, gd, ext);
    checks++;
    if (ga !== 1'b1 || gd !== e_dat) begin
      errors++; $display("FAIL reset_ram_kept_0x20: ack=%b dat=%h, want 1 %h", ga, gd, e_dat);
    end
  endtask

  task automatic test_random();
    int lat; logic ga, ge, ext, e_err, w; logic [31:0] gd, e_dat, a, d; logic [3:0] s;
    for (int dut = 0; dut < NDUT; dut++) begin
      sel = dut;
      for (int k = 16; k < 32; k++) begin
        d = $urandom();
        model_access(1'b1, 32'(k * 4), 4'hF, d, e_err, e_dat);
        bus_xfer(1'b1, 32'(k * 4), 4'hF, d, lat, ga, ge, gd, ext);
      end
      for (int op = 0; op < 30; op++) begin
        w = 1'($urandom_range(0, 1));
        s = 4'($urandom_range(1, 15));
        d = $urandom();
        if ($urandom_range(0, 7) == 0) a = $urandom() | 32'h0000_1000;
        else a = 32'h40 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
        model_access(w, a, s, d, e_err, e_dat);
        bus_xfer(w, a, s, d, lat, ga, ge, gd, ext);
        checks++;
        if (ga !== !e_err || ge !== e_err || ext !== 1'b0 || lat != ws_of(sel) + 1
            || ((e_err || !w) && gd !== e_dat)) begin
          errors++;
          $display("FAIL random dut%0d op%0d we=%b a=%h s=%b: ack=%b err=%b tail=%b lat=%0d dat=%h, want ack=%b err=%b lat=%0d dat=%h",
                   sel, op, w, a, s, ga, ge, ext, lat, gd, !e_err, e_err, ws_of(sel) + 1, e_dat);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    sel = 0; cyc = 1'b0; stb = '0; we = 1'b0; addr = '0; wdat = '0;
    i_reset_n = 1'b0;
    repeat (3) @(negedge i_clk);
    test_reset();
    i_reset_n = 1'b1;
    test_basic();
    test_byte_lanes();
    test_errors();
    test_abort();
    test_hold();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
